// File: rtl/draw_text_16x16.sv
// Text panel overlay: maps pixel position to text/font ROM addresses and
// paints set font pixels over the 4-clock delayed VGA stream.
module draw_text_16x16 #(
    parameter int          XPOS         = 16,
    parameter int          YPOS         = 16,
    parameter int          COLS         = 12,
    parameter int          ROWS         = 14,
    parameter logic [11:0] LETTER_COLOR = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [7:0]  char_pixels,
    output logic [7:0]  char_xy,
    output logic [3:0]  char_line,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam logic [10:0] X0 = 11'(XPOS);
    localparam logic [10:0] X1 = 11'(XPOS + 8 * COLS);
    localparam logic [10:0] Y0 = 11'(YPOS);
    localparam logic [10:0] Y1 = 11'(YPOS + 16 * ROWS);

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic        in_area;
        logic [2:0]  xo;
    } pix_t;

    logic        w_in_area;
    logic [10:0] w_xo;
    logic [10:0] w_yo;
    logic [7:0]  w_idx;
    logic [7:0]  w_char_xy;
    pix_t        w_s0;
    logic        w_pix_on;
    logic [11:0] w_rgb;

    pix_t        r_s1;
    pix_t        r_s2;
    pix_t        r_s3;
    logic [3:0]  r_line1;

    // Compare before subtracting so offsets never wrap outside the panel.
    always_comb begin
        w_in_area = (hcount_in >= X0) && (hcount_in < X1) &&
                    (vcount_in >= Y0) && (vcount_in < Y1);
        w_xo      = w_in_area ? (hcount_in - X0) : 11'd0;
        w_yo      = w_in_area ? (vcount_in - Y0) : 11'd0;
        w_idx     = 8'(w_yo[10:4]) * 8'(COLS) + 8'(w_xo[10:3]);
        w_char_xy = w_in_area ? w_idx : 8'hFF;
    end

    always_comb begin
        w_s0.h       = hcount_in;
        w_s0.v       = vcount_in;
        w_s0.hs      = hsync_in;
        w_s0.vs      = vsync_in;
        w_s0.hb      = hblnk_in;
        w_s0.vb      = vblnk_in;
        w_s0.rgb     = rgb_in;
        w_s0.in_area = w_in_area;
        w_s0.xo      = w_xo[2:0];
    end

    always_comb begin
        w_pix_on = r_s3.in_area && char_pixels[3'd7 - r_s3.xo];
        if (r_s3.hb || r_s3.vb)
            w_rgb = 12'h000;
        else if (w_pix_on)
            w_rgb = LETTER_COLOR;
        else
            w_rgb = r_s3.rgb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_s3       <= '0;
            r_line1    <= '0;
            char_xy    <= '0;
            char_line  <= '0;
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            r_s1       <= w_s0;
            char_xy    <= w_char_xy;
            r_line1    <= w_yo[3:0];
            r_s2       <= r_s1;
            char_line  <= r_line1;
            r_s3       <= r_s2;
            hcount_out <= r_s3.h;
            vcount_out <= r_s3.v;
            hsync_out  <= r_s3.hs;
            vsync_out  <= r_s3.vs;
            hblnk_out  <= r_s3.hb;
            vblnk_out  <= r_s3.vb;
            rgb_out    <= w_rgb;
        end
    end

endmodule

// File: tb/tb_draw_text_16x16.sv
// Directed bench for draw_text_16x16: reset, corners, blanking and a
// streamed scan against text/font ROM models.
module tb_draw_text_16x16;

    logic        clk;
    logic        rst;
    logic [10:0] hcount_in;
    logic [10:0] vcount_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        hblnk_in;
    logic        vblnk_in;
    logic [11:0] rgb_in;
    logic [7:0]  char_pixels;
    logic [7:0]  char_xy;
    logic [3:0]  char_line;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;

    logic        use_rom;
    logic [7:0]  pix_dir;
    logic [7:0]  rom_code;
    logic [7:0]  rom_pix;

    int n_cmp = 0;
    int n_bad = 0;

    draw_text_16x16 dut (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .char_pixels(char_pixels),
        .char_xy(char_xy), .char_line(char_line),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] font(input logic [7:0] code,
                                        input logic [3:0] line);
        return (code == 8'h00) ? 8'h00 : (code ^ {line, ~line});
    endfunction

    // Text ROM returns a space (code 0) for index 0xFF.
    always @(posedge clk) begin
        rom_code <= (char_xy == 8'hFF) ? 8'h00 : char_xy + 8'h01;
        rom_pix  <= font(rom_code, char_line);
    end

    assign char_pixels = use_rom ? rom_pix : pix_dir;

    function automatic logic [7:0] ref_xy(input int h, input int v);
        if (h < 16 || h >= 112 || v < 16 || v >= 240) return 8'hFF;
        return 8'(((v - 16) / 16) * 12 + (h - 16) / 8);
    endfunction

    function automatic logic [11:0] ref_rgb(input int h, input int v,
                                            input logic hb, input logic vb,
                                            input logic [11:0] rgb);
        logic [7:0] px;
        if (hb || vb) return 12'h000;
        if (h < 16 || h >= 112 || v < 16 || v >= 240) return rgb;
        px = font(ref_xy(h, v) + 8'h01, 4'((v - 16) % 16));
        return px[7 - ((h - 16) % 8)] ? 12'hFFF : rgb;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int h, input int v, input logic hs,
                         input logic vs, input logic hb, input logic vb,
                         input logic [11:0] rgb);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hsync_in  = hs;
        vsync_in  = vs;
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = rgb;
    endtask

    task automatic dir(input string tag, input int h, input int v,
                       input logic hb, input logic [11:0] rgb,
                       input logic [7:0] pix, input logic [7:0] exy,
                       input logic [3:0] eline, input logic [11:0] ergb);
        drive(h, v, 1'b1, 1'b0, hb, 1'b0, rgb);
        pix_dir = pix;
        step();
        chk({tag, "_xy"}, 64'(char_xy), 64'(exy));
        step();
        chk({tag, "_line"}, 64'(char_line), 64'(eline));
        step();
        step();
        chk({tag, "_rgb"}, 64'(rgb_out), 64'(ergb));
        chk({tag, "_pos"}, {hcount_out, vcount_out, hblnk_out, hsync_out},
            {11'(h), 11'(v), hb, 1'b1});
    endtask

    int          hh   [2048];
    int          vv   [2048];
    logic [3:0]  tt   [2048];
    logic [11:0] er   [2048];
    logic [7:0]  ex   [2048];
    int          rows [6] = '{15, 16, 31, 100, 239, 240};

    initial begin
        int n;
        use_rom = 1'b0;
        pix_dir = 8'h00;
        rst     = 1'b1;
        drive($urandom_range(0, 2047), $urandom_range(0, 2047), 1'b1, 1'b1,
              1'b0, 1'b0, 12'($urandom));
        pix_dir = 8'($urandom);
        step();
        chk("rst0", {char_xy, char_line, hcount_out, vcount_out, hsync_out,
                     vsync_out, hblnk_out, vblnk_out, rgb_out}, 64'd0);
        drive($urandom_range(0, 2047), $urandom_range(0, 2047), 1'b1, 1'b1,
              1'b0, 1'b0, 12'($urandom));
        pix_dir = 8'($urandom);
        step();
        chk("rst1", {char_xy, char_line, hcount_out, vcount_out, hsync_out,
                     vsync_out, hblnk_out, vblnk_out, rgb_out}, 64'd0);

        rst = 1'b0;
        drive(500, 500, 1'b0, 1'b0, 1'b0, 1'b0, 12'hABC);
        pix_dir = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rel_rgb0", 64'(rgb_out), 64'd0);
        end
        step();
        chk("rel_rgb", 64'(rgb_out), 64'hABC);
        chk("rel_h", 64'(hcount_out), 64'd500);

        dir("tl",    16,  16,  1'b0, 12'h0A5, 8'h80, 8'h00, 4'd0,  12'hFFF);
        dir("br",    111, 239, 1'b0, 12'h0A5, 8'h01, 8'hA7, 4'd15, 12'hFFF);
        dir("br_off", 111, 239, 1'b0, 12'h321, 8'hFE, 8'hA7, 4'd15, 12'h321);
        dir("mid",   42,  53,  1'b0, 12'h123, 8'hDF, 8'h1B, 4'd5,  12'h123);
        dir("right", 112, 16,  1'b0, 12'h456, 8'hFF, 8'hFF, 4'd0,  12'h456);
        dir("below", 16,  240, 1'b0, 12'h789, 8'hFF, 8'hFF, 4'd0,  12'h789);
        dir("left",  15,  16,  1'b0, 12'h246, 8'hFF, 8'hFF, 4'd0,  12'h246);
        dir("blank", 16,  16,  1'b1, 12'h777, 8'hFF, 8'h00, 4'd0,  12'h000);

        use_rom = 1'b1;
        n = 0;
        foreach (rows[r]) begin
            for (int h = 0; h < 128; h++) begin
                hh[n] = h;
                vv[n] = rows[r];
                tt[n] = {h[3], rows[r][0] ^ h[5], h >= 120,
                         rows[r] == 100 && h < 8};
                er[n] = ref_rgb(h, rows[r], tt[n][1], tt[n][0],
                                12'(h * 37 + rows[r]));
                ex[n] = ref_xy(h, rows[r]);
                drive(h, rows[r], tt[n][3], tt[n][2], tt[n][1], tt[n][0],
                      12'(h * 37 + rows[r]));
                step();
                n++;
                chk("s_xy", 64'(char_xy), 64'(ex[n-1]));
                if (n >= 4) begin
                    chk("s_pos", {hcount_out, vcount_out},
                        {11'(hh[n-4]), 11'(vv[n-4])});
                    chk("s_tim", {hsync_out, vsync_out, hblnk_out, vblnk_out},
                        64'(tt[n-4]));
                    chk("s_rgb", 64'(rgb_out), 64'(er[n-4]));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/draw_text_16x16.md
# draw_text_16x16

Video-pipeline stage that overlays the 14-row × 12-column channel-voltage text panel on the VGA stream. It sits around the text ROM: it converts the incoming pixel position into the character index `char_xy` that the text ROM consumes, and the font-row number `char_line` for the font ROM. It then takes the returned 8-pixel font row `char_pixels` and paints letter pixels into the delayed RGB stream. All VGA timing signals are delayed so they stay aligned with the colour.

## Interface
Parameters:
- `XPOS` — 16 — left pixel column of the text panel
- `YPOS` — 16 — top pixel row of the text panel
- `COLS` — 12 — characters per text row; `COLS*ROWS` ≤ 256
- `ROWS` — 14 — text rows
- `LETTER_COLOR` — 12'hFFF — RGB444 colour of set font pixels

Ports:
- `clk` — in — 1 — pixel clock, single clock domain
- `rst` — in — 1 — synchronous, active-high reset
- `hcount_in`, `vcount_in` — in — 11 each — pixel position
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in` — in — 1 each — timing
- `rgb_in` — in — 12 — background colour
- `char_pixels` — in — 8 — font row from the font ROM; MSB is the leftmost pixel
- `char_xy` — out — 8 — character index to the text ROM
- `char_line` — out — 4 — font row to the font ROM
- `hcount_out`, `vcount_out` — out — 11 each — delayed position
- `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out` — out — 1 each — delayed timing
- `rgb_out` — out — 12 — composited colour

## Operation
- Character cell is 8 px wide × 16 px tall.
- Derived offsets: `xo = hcount_in − XPOS`, `yo = vcount_in − YPOS`. Compute with 11-bit unsigned arithmetic and compare before subtracting, so there is no underflow.
- In-area condition `in_area`: `XPOS ≤ hcount_in < XPOS + 8·COLS` and `YPOS ≤ vcount_in < YPOS + 16·ROWS`.
- Index mapping:
  - In area: `char_xy = (yo>>4)·COLS + (xo>>3)`, truncated to 8 bits.
  - Outside the area: `char_xy = 8'hFF`, which the text ROM returns as a space.
  - `char_line = yo[3:0]` in area, 0 otherwise.
- Pipeline stages, numbered by the clock edge after the inputs are sampled:
  - E1: register `char_xy`, `char_line`, `in_area`, `xo[2:0]`, all timing signals and `rgb_in`.
  - E2: the text ROM registers `char_code`. This block re-registers `char_line` onto the output port so it is aligned with `char_code`, and delays the rest.
  - E3: the font ROM registers `char_pixels` from `{char_code, char_line}`. This block delays its internal state one more stage.
  - E4: register the outputs:
    - If delayed `hblnk` or `vblnk` is set: `rgb_out = 12'h000`.
    - Else if delayed `in_area` and `char_pixels[7 − xo_d[2:0]]` is set: `rgb_out = LETTER_COLOR`.
    - Else: `rgb_out` = delayed `rgb_in`.
  - Timing and count outputs are the inputs delayed by exactly 4 clocks.
- There is no backpressure and no handshake; one pixel is accepted per clock, every clock.

## Timing
- Latency: `char_xy` 1 clock; `char_line` 2 clocks; all video outputs 4 clocks.
- Throughput: 1 pixel per clock.
- Reset: every register clears on the first rising edge with `rst`=1.
  - All outputs become 0, including `char_xy` = 8'h00, `char_line` = 0 and `rgb_out` = 0.
  - Pipeline contents are discarded.
- Reset asserted mid-frame: outputs are 0 from the next edge.
  - After `rst` deasserts, `rgb_out`, timing and count outputs stay 0 for 3 further clocks.
  - Valid data appears on the 4th edge after release.
- Boundaries:
  - Last panel pixel (`XPOS+8·COLS−1`, `YPOS+16·ROWS−1`) maps to index `COLS·ROWS−1` (0xA7 at defaults), line 15.
  - The next pixel right or below maps to 0xFF.
- Blanking overrides letter colour even when in area.

## Test plan
- Reset: hold `rst` 2 clocks with random inputs -> all outputs 0 during reset. After release, `rgb_out` stays 0 for 3 clocks, then tracks the input.
- Top-left corner: `hcount_in`=16, `vcount_in`=16 -> `char_xy`=0x00 after 1 clock, `char_line`=0 after 2 clocks. With `char_pixels`=8'h80, `rgb_out`=12'hFFF after 4 clocks.
- Bottom-right corner: `hcount_in`=111, `vcount_in`=239 -> `char_xy`=0xA7 and `char_line`=15. With `char_pixels`=8'h01 (xo[2:0]=7), `rgb_out`=12'hFFF.
- Mid-panel pixel: `hcount_in`=16+8·3+2, `vcount_in`=16+16·2+5 -> `char_xy`=27, `char_line`=5. With `char_pixels`=8'hDF (bit 5 clear), `rgb_out` = `rgb_in` 12'h123.
- Outside and blanking:
  - `hcount_in`=112, `vcount_in`=16 -> `char_xy`=0xFF and `rgb_out` = `rgb_in`.
  - In area with `hblnk_in`=1 and `char_pixels`=8'hFF -> `rgb_out`=0.
- Full frame: 1024×768 timing stream with a text ROM and font ROM model -> every sync, blank and count output equals the input delayed 4 clocks. Letter pixels appear only inside the 96×224 panel.
